serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a 1-bit full-adder cell.
- Accepts two WIDTH-bit operands over a valid/ready handshake, processes them LSB-first one bit per clock with a registered carry, and presents the WIDTH-bit sum plus carry-out over a second valid/ready handshake.
- Sits in the arithmetic datapath as the multi-bit sequencer that feeds the 1-bit adder cell and consumes its sum/carry outputs.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder sequencer.
package serial_adder_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder used as the serial adder's arithmetic core.
module full_adder_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ cin;
   assign co = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first, one bit per clock, registered carry.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input for a - b.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   sum_r;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               cout_r;
   logic               out_valid_r;
   logic               fa_s;
   logic               fa_co;
   logic [WIDTH-1:0]   b_load;
   logic               carry_load;

   full_adder_cell u_fa (
      .x   (a_sh[0]),
      .y   (b_sh[0]),
      .cin (carry),
      .s   (fa_s),
      .co  (fa_co)
   );

   // Subtraction is a + ~b + 1: invert b and seed the carry at load time.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub;
`else
   assign b_load     = b;
   assign carry_load = 1'b0;
`endif

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid)        state_d = ST_SHIFT;
         ST_SHIFT: if (cnt == CNT_LAST) state_d = ST_DONE;
         ST_DONE:  if (out_ready)       state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh        <= '0;
         b_sh        <= '0;
         sum_r       <= '0;
         cnt         <= '0;
         carry       <= 1'b0;
         cout_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b_load;
                  carry <= carry_load;
                  cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               sum_r <= {fa_s, sum_r[WIDTH-1:1]};
               a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
               carry <= fa_co;
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  out_valid_r <= 1'b1;
                  cout_r      <= fa_co;
               end
            end
            ST_DONE: begin
               if (out_ready) out_valid_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one operand pair through the accept edge and push its expected result.
   task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
      exp_t           e;
      logic [W:0]     full;
      int             n;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      if (sv) full = {1'b0, av} + {1'b0, ~bv} + 9'd1;
      else    full = {1'b0, av} + {1'b0, bv};
      e.s = full[W-1:0];
      e.c = full[W];
      q.push_back(e);
`ifdef SERIAL_ADDER_SUB_EN
      sub = sv;
`endif
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      tick();
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      chk("in_ready_after_accept", 32'(in_ready), 32'd0);
   endtask

   // Wait for out_valid (bounded), check latency from accept and the popped result.
   task automatic collect(input string tag);
      exp_t e;
      int   cyc;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(W));
      if (q.size() == 0) begin
         chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = q.pop_front();
         chk({tag, "_sum"}, 32'(sum), 32'(e.s));
         chk({tag, "_cout"}, 32'(cout), 32'(e.c));
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int bad;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub       = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_sum", 32'(sum), 32'd0);
      chk("reset_cout", 32'(cout), 32'd0);

      accept(8'h05, 8'h03, 1'b0); collect("add_05_03"); handshake("add_05_03");
      accept(8'hFF, 8'h01, 1'b0); collect("add_ff_01"); handshake("add_ff_01");
      accept(8'h80, 8'h80, 1'b0); collect("add_80_80"); handshake("add_80_80");
      accept(8'h00, 8'h00, 1'b0); collect("add_00_00"); handshake("add_00_00");

      // Backpressure: result held, new operands offered but not taken.
      out_ready = 1'b0;
      accept(8'h11, 8'h22, 1'b0);
      collect("bp_11_22");
      in_valid = 1'b1;
      a        = 8'hAA;
      b        = 8'hBB;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_sum", 32'(sum), 32'h33);
         chk("bp_hold_cout", 32'(cout), 32'd0);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      q.push_back('{s: 8'h65, c: 1'b1});
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("bp_new_accepted", 32'(in_ready), 32'd0);
      collect("bp_aa_bb");
      handshake("bp_aa_bb");

      // Reset on the 4th SHIFT edge abandons the operation.
      accept(8'hAA, 8'h55, 1'b0);
      void'(q.pop_back());
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_sum", 32'(sum), 32'd0);
      chk("rst_mid_cout", 32'(cout), 32'd0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) bad++;
         tick();
      end
      chk("rst_mid_no_result", 32'(bad), 32'd0);
      accept(8'h10, 8'h20, 1'b0); collect("add_10_20"); handshake("add_10_20");

`ifdef SERIAL_ADDER_SUB_EN
      accept(8'h05, 8'h03, 1'b1); collect("sub_05_03"); handshake("sub_05_03");
      accept(8'h03, 8'h05, 1'b1); collect("sub_03_05"); handshake("sub_03_05");
      accept(8'h05, 8'h03, 1'b0); collect("sub0_05_03"); handshake("sub0_05_03");
`endif

      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
